// File: rtl/match3_pkg.sv
// Shared board geometry, cell packing and refill FSM encoding
// for the match-3 board datapath blocks.
package match3_pkg;

    localparam int BOARD_DIM = 8;
    localparam int CELL_W    = 3;
    localparam int BOARD_W   = BOARD_DIM * BOARD_DIM * CELL_W;

    localparam logic [2:0] CELL_EMPTY = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FILL,
        ST_DONE
    } state_t;

    function automatic int cell_off(
        input logic [2:0] row,
        input logic [2:0] col
    );
        return (int'(row) * BOARD_DIM + int'(col)) * CELL_W;
    endfunction

endpackage

// File: rtl/lfsr_color_gen.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed
// load, mapped to a non-empty colour code 1..NUM_COLORS.
module lfsr_color_gen #(
    parameter int          NUM_COLORS = 6,
    parameter logic [15:0] LFSR_INIT  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [2:0]  colour
);

    localparam logic [2:0] NC3 = 3'(NUM_COLORS);

    logic [15:0] lfsr;
    logic        fb;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // An all-zero seed would lock the LFSR, so it maps to the init value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_INIT;
        end else if (seed_load) begin
            lfsr <= (seed == 16'd0) ? LFSR_INIT : seed;
        end else begin
            lfsr <= {lfsr[14:0], fb};
        end
    end

    assign colour = (lfsr[2:0] % NC3) + 3'd1;

endmodule

// File: rtl/board_refill.sv
// Column gravity plus random refill of a cleared board: one cell per
// cycle scan, then one cycle per generated cell, start/done handshake.
module board_refill
    import match3_pkg::*;
#(
    parameter int          NUM_COLORS = 6,
    parameter logic [15:0] LFSR_INIT  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BOARD_W-1:0] board_in,
    input  logic               seed_load,
    input  logic [15:0]        seed,
    output logic               busy,
    output logic               done,
    output logic [BOARD_W-1:0] board_out,
    output logic [6:0]         filled_count
);

    state_t             state;
    logic [BOARD_W-1:0] work;
    logic [2:0]         r;
    logic [2:0]         c;
    logic [3:0]         wr;
    logic [6:0]         count;
    logic [2:0]         colour;
    logic [2:0]         cur;
    logic               keep;
    logic [3:0]         wr_after;
    logic               col_end;

    lfsr_color_gen #(
        .NUM_COLORS (NUM_COLORS),
        .LFSR_INIT  (LFSR_INIT)
    ) u_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .colour    (colour)
    );

    // Current scan cell, next write row, and end-of-column detection.
    always_comb begin
        cur      = work[cell_off(r, c) +: CELL_W];
        keep     = (cur != CELL_EMPTY);
        wr_after = keep ? (wr - 4'd1) : wr;
        col_end  = 1'b0;
        if (state == ST_SCAN) begin
            col_end = (r == 3'd0) && (wr_after == 4'hF);
        end else if (state == ST_FILL) begin
            col_end = (wr == 4'd0);
        end
    end

    // Refill FSM: latch, compact each column downward, top up, publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            work         <= '0;
            r            <= 3'd0;
            c            <= 3'd0;
            wr           <= 4'd0;
            count        <= 7'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            board_out    <= '0;
            filled_count <= 7'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        work  <= board_in;
                        c     <= 3'd0;
                        r     <= 3'd7;
                        wr    <= 4'd7;
                        count <= 7'd0;
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (keep) begin
                        work[cell_off(wr[2:0], c) +: CELL_W] <= cur;
                        if (wr[2:0] != r) begin
                            work[cell_off(r, c) +: CELL_W] <= CELL_EMPTY;
                        end
                    end
                    wr <= wr_after;
                    if (r == 3'd0) begin
                        state <= ST_FILL;
                    end else begin
                        r <= r - 3'd1;
                    end
                end
                ST_FILL: begin
                    work[cell_off(wr[2:0], c) +: CELL_W] <= colour;
                    count <= count + 7'd1;
                    wr    <= wr - 4'd1;
                end
                ST_DONE: begin
                    board_out    <= work;
                    filled_count <= count;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
            if (col_end) begin
                if (c == 3'd7) begin
                    state <= ST_DONE;
                end else begin
                    c     <= c + 3'd1;
                    r     <= 3'd7;
                    wr    <= 4'd7;
                    state <= ST_SCAN;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_refill.sv
// Randomized bench for board_refill against a column-list model
// that replays a reference LFSR history by cycle index.
module tb_board_refill;
    import match3_pkg::*;

    localparam int          NC   = 6;
    localparam logic [15:0] INIT = 16'hACE1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         seed_load = 1'b0;
    logic [191:0] board_in = '0;
    logic [15:0]  seed = '0;
    logic         busy;
    logic         done;
    logic [191:0] board_out;
    logic [6:0]   filled_count;

    int checks = 0;
    int failures = 0;

    board_refill #(
        .NUM_COLORS (NC),
        .LFSR_INIT  (INIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .board_in     (board_in),
        .seed_load    (seed_load),
        .seed         (seed),
        .busy         (busy),
        .done         (done),
        .board_out    (board_out),
        .filled_count (filled_count)
    );

    always #5 clk = ~clk;

    // Reference random source: value held before each counted edge.
    logic [15:0] m_lfsr = INIT;
    int          cyc = 0;
    logic [15:0] hist [0:8191];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [2:0] colour_of(input logic [15:0] l);
        int v;
        v = (int'(l[2:0]) % NC) + 1;
        return 3'(v);
    endfunction

    function automatic logic [2:0] get_cell(input logic [191:0] b,
                                            input int r, input int c);
        return b[(r * 8 + c) * 3 +: 3];
    endfunction

    function automatic logic [191:0] put_cell(input logic [191:0] b,
                                              input int r, input int c,
                                              input logic [2:0] v);
        logic [191:0] o;
        o = b;
        o[(r * 8 + c) * 3 +: 3] = v;
        return o;
    endfunction

    // Track the spec LFSR so refill colours can be predicted per cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= INIT;
        end else begin
            hist[cyc % 8192] <= m_lfsr;
            cyc <= cyc + 1;
            if (seed_load) m_lfsr <= (seed == 16'd0) ? INIT : seed;
            else           m_lfsr <= lfsr_next(m_lfsr);
        end
    end

    task automatic chk(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] full_board();
        logic [191:0] b;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b = put_cell(b, r, c, 3'(((r + c) % 6) + 1));
        return b;
    endfunction

    task automatic reseed(input logic [15:0] v);
        seed = v;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic run_board(input string tag, input logic [191:0] b,
                             input bit pulse_mid);
        int s, lat, ndone, empt, t, k, cnt, fill;
        bit got;
        logic [191:0] exp, cap;
        logic [6:0] cap_fc;
        empt = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (get_cell(b, r, c) == 3'd0) empt++;
        board_in = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc - 1;
        chk({tag, "_busy"}, 192'(busy), 192'(1));
        got = 0; ndone = 0; lat = 0; cap = '0; cap_fc = '0;
        for (int n = 1; n <= 300; n++) begin
            start = (pulse_mid && n == 10);
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (!got) begin
                    got = 1;
                    lat = cyc - 1 - s;
                    cap = board_out;
                    cap_fc = filled_count;
                end
            end
            if (got && (cyc - 1 - s) >= lat + 4) break;
        end
        start = 1'b0;
        if (!got) begin
            chk({tag, "_timeout"}, 192'(0), 192'(1));
            return;
        end
        exp = '0; cnt = 0; t = s + 1;
        for (int c = 0; c < 8; c++) begin
            k = 0;
            for (int r = 7; r >= 0; r--) begin
                if (get_cell(b, r, c) != 3'd0) begin
                    exp = put_cell(exp, 7 - k, c, get_cell(b, r, c));
                    k++;
                end
            end
            t += 8;
            fill = 8 - k;
            for (int w = fill - 1; w >= 0; w--) begin
                exp = put_cell(exp, w, c, colour_of(hist[t % 8192]));
                t++;
            end
            cnt += fill;
        end
        chk({tag, "_lat"}, 192'(lat), 192'(65 + empt));
        chk({tag, "_board"}, cap, exp);
        chk({tag, "_count"}, 192'(cap_fc), 192'(cnt));
        chk({tag, "_ndone"}, 192'(ndone), 192'(1));
        chk({tag, "_idle"}, 192'(busy), 192'(0));
        chk({tag, "_hold"}, board_out, exp);
    endtask

    initial begin
        logic [191:0] b;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_done", 192'(done), 192'(0));
        chk("rst_board", board_out, 192'(0));
        chk("rst_count", 192'(filled_count), 192'(0));

        run_board("full", full_board(), 1'b0);

        b = full_board();
        for (int r = 0; r < 8; r++)
            b = put_cell(b, r, 3, (r < 5) ? 3'(r + 1) : 3'd0);
        run_board("col3", b, 1'b0);

        reseed(16'h0000);
        run_board("empty", '0, 1'b0);

        b = full_board();
        b = put_cell(b, 0, 0, 3'd7);
        b = put_cell(b, 1, 0, 3'd0);
        b = put_cell(b, 2, 0, 3'd6);
        b = put_cell(b, 3, 0, 3'd5);
        b = put_cell(b, 4, 0, 3'd0);
        b = put_cell(b, 5, 0, 3'd4);
        b = put_cell(b, 6, 0, 3'd0);
        b = put_cell(b, 7, 0, 3'd3);
        run_board("col0", b, 1'b0);

        run_board("midstart", full_board() ^ {64{3'b000}}, 1'b1);

        board_in = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("abort_busy", 192'(busy), 192'(0));
        chk("abort_done", 192'(done), 192'(0));
        chk("abort_board", board_out, 192'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_board("fresh", b, 1'b0);

        for (int i = 0; i < 6; i++) begin
            b = '0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if ($urandom_range(0, 99) >= i * 15)
                        b = put_cell(b, r, c, 3'($urandom_range(1, 7)));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            run_board($sformatf("rnd%0d", i), b, 1'b0);
        end

        reseed(16'h1234);
        run_board("seedA", b, 1'b0);
        reseed(16'h1234);
        run_board("seedB", b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
